axi_ad9234_capture_ctrl: RTL and testbench



---
 rtl/ad_capture_pkg.sv | 25 ++
 rtl/ad_capture_trig.sv | 39 +++
 rtl/axi_ad9234_capture_ctrl.sv | 161 ++++++++++++++++
 tb/tb_axi_ad9234_capture_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ad_capture_pkg.sv
// Shared definitions for the AD9234 capture sequencer: state encodings,
// trigger-mode codes and default counter widths.
package ad_capture_pkg;

    localparam int unsigned AD_COUNT_WIDTH   = 16;
    localparam int unsigned AD_HOLDOFF_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_HOLDOFF = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } cap_state_e;

    localparam logic [1:0] TRIG_IMM   = 2'd0;
    localparam logic [1:0] TRIG_EDGE  = 2'd1;
    localparam logic [1:0] TRIG_LEVEL = 2'd2;
    localparam logic [1:0] TRIG_RSVD  = 2'd3;

    function automatic logic is_busy(input cap_state_e s);
        return (s == ST_ARMED) || (s == ST_HOLDOFF) || (s == ST_CAPTURE);
    endfunction

endpackage

// File: rtl/ad_capture_trig.sv
// Trigger qualification: selects immediate, rising-edge or level trigger and
// keeps the trig_in history used for edge detection.
module ad_capture_trig
    import ad_capture_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_trig_mode,
    input  logic       i_trig_in,
    output logic       o_trig_hit
);

    logic r_trig_prev;
    logic w_trig_hit;

    // History resets high so a trigger held high through reset is not an edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_trig_prev <= 1'b1;
        end else begin
            r_trig_prev <= i_trig_in;
        end
    end

    // Mode mux; the reserved code falls back to immediate.
    always_comb begin
        w_trig_hit = 1'b1;
        case (i_trig_mode)
            TRIG_IMM:   w_trig_hit = 1'b1;
            TRIG_EDGE:  w_trig_hit = i_trig_in & ~r_trig_prev;
            TRIG_LEVEL: w_trig_hit = i_trig_in;
            TRIG_RSVD:  w_trig_hit = 1'b1;
            default:    w_trig_hit = 1'b1;
        endcase
    end

    assign o_trig_hit = w_trig_hit;

endmodule

// File: rtl/axi_ad9234_capture_ctrl.sv
// Capture sequencer: arm, trigger, holdoff, then gate cfg_length beats of both
// AD9234 channels onto the DMA write strobes.
module axi_ad9234_capture_ctrl
    import ad_capture_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH   = AD_COUNT_WIDTH,
    parameter int unsigned HOLDOFF_WIDTH = AD_HOLDOFF_WIDTH
) (
    input  logic                     adc_clk,
    input  logic                     adc_rst,
    input  logic                     cfg_arm,
    input  logic                     cfg_abort,
    input  logic [COUNT_WIDTH-1:0]   cfg_length,
    input  logic [HOLDOFF_WIDTH-1:0] cfg_holdoff,
    input  logic [1:0]               cfg_trig_mode,
    input  logic                     trig_in,
    input  logic                     adc_enable_0,
    input  logic                     adc_enable_1,
    input  logic [63:0]              adc_data_a,
    input  logic [63:0]              adc_data_b,
    input  logic                     adc_dovf,
    output logic                     adc_valid_0,
    output logic                     adc_valid_1,
    output logic [63:0]              adc_data_0,
    output logic [63:0]              adc_data_1,
    output logic [2:0]               sts_state,
    output logic                     sts_busy,
    output logic                     sts_done,
    output logic                     sts_ovf,
    output logic [COUNT_WIDTH-1:0]   sts_count
);

    localparam logic [COUNT_WIDTH-1:0]   LP_CNT_ZERO  = {COUNT_WIDTH{1'b0}};
    localparam logic [COUNT_WIDTH-1:0]   LP_CNT_ONE   = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [HOLDOFF_WIDTH-1:0] LP_HOLD_ZERO = {HOLDOFF_WIDTH{1'b0}};
    localparam logic [HOLDOFF_WIDTH-1:0] LP_HOLD_ONE  = {{(HOLDOFF_WIDTH-1){1'b0}}, 1'b1};

    cap_state_e               r_state;
    cap_state_e               w_state_nxt;
    logic [COUNT_WIDTH-1:0]   r_len;
    logic [HOLDOFF_WIDTH-1:0] r_hold_len;
    logic [HOLDOFF_WIDTH-1:0] r_hold_cnt;
    logic [COUNT_WIDTH-1:0]   r_beat_cnt;
    logic [COUNT_WIDTH-1:0]   r_count;
    logic                     r_done;
    logic                     r_ovf;
    logic                     r_busy;
    logic                     r_valid_0;
    logic                     r_valid_1;
    logic [63:0]              r_data_0;
    logic [63:0]              r_data_1;
    logic                     w_trig_hit;
    logic                     w_arm_ok;
    logic                     w_beat;
    logic                     w_enter_capture;
    logic                     w_enter_holdoff;

    ad_capture_trig u_trig (
        .i_clk       (adc_clk),
        .i_rst       (adc_rst),
        .i_trig_mode (cfg_trig_mode),
        .i_trig_in   (trig_in),
        .o_trig_hit  (w_trig_hit)
    );

    // Next-state logic; abort overrides everything, including a same-cycle arm.
    always_comb begin
        w_arm_ok = cfg_arm && !cfg_abort && (cfg_length != LP_CNT_ZERO) &&
                   ((r_state == ST_IDLE) || (r_state == ST_DONE));
        w_beat      = (r_state == ST_CAPTURE) && !cfg_abort;
        w_state_nxt = r_state;
        if (cfg_abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_arm_ok) w_state_nxt = ST_ARMED;
                    else          w_state_nxt = ST_IDLE;
                end
                ST_ARMED: begin
                    if (!w_trig_hit)                  w_state_nxt = ST_ARMED;
                    else if (r_hold_len == LP_HOLD_ZERO) w_state_nxt = ST_CAPTURE;
                    else                              w_state_nxt = ST_HOLDOFF;
                end
                ST_HOLDOFF: begin
                    if (r_hold_cnt == LP_HOLD_ONE) w_state_nxt = ST_CAPTURE;
                    else                           w_state_nxt = ST_HOLDOFF;
                end
                ST_CAPTURE: begin
                    if (r_beat_cnt == LP_CNT_ONE) w_state_nxt = ST_DONE;
                    else                          w_state_nxt = ST_CAPTURE;
                end
                ST_DONE: begin
                    if (w_arm_ok) w_state_nxt = ST_ARMED;
                    else          w_state_nxt = ST_DONE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
        w_enter_capture = (w_state_nxt == ST_CAPTURE) && (r_state != ST_CAPTURE);
        w_enter_holdoff = (w_state_nxt == ST_HOLDOFF) && (r_state == ST_ARMED);
    end

    // State, counters, sticky status and the registered DMA outputs.
    always_ff @(posedge adc_clk or posedge adc_rst) begin
        if (adc_rst) begin
            r_state    <= ST_IDLE;
            r_len      <= LP_CNT_ZERO;
            r_hold_len <= LP_HOLD_ZERO;
            r_hold_cnt <= LP_HOLD_ZERO;
            r_beat_cnt <= LP_CNT_ZERO;
            r_count    <= LP_CNT_ZERO;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            r_busy     <= 1'b0;
            r_valid_0  <= 1'b0;
            r_valid_1  <= 1'b0;
            r_data_0   <= 64'd0;
            r_data_1   <= 64'd0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= is_busy(w_state_nxt);

            if (w_arm_ok) begin
                r_len      <= cfg_length;
                r_hold_len <= cfg_holdoff;
            end

            if (w_enter_holdoff)              r_hold_cnt <= r_hold_len;
            else if (r_state == ST_HOLDOFF)   r_hold_cnt <= r_hold_cnt - LP_HOLD_ONE;

            if (w_enter_capture)  r_beat_cnt <= r_len;
            else if (w_beat)      r_beat_cnt <= r_beat_cnt - LP_CNT_ONE;

            if (w_arm_ok)     r_count <= LP_CNT_ZERO;
            else if (w_beat)  r_count <= r_count + LP_CNT_ONE;

            if (w_arm_ok)                                r_done <= 1'b0;
            else if (w_beat && (r_beat_cnt == LP_CNT_ONE)) r_done <= 1'b1;

            if (w_arm_ok)                               r_ovf <= 1'b0;
            else if (adc_dovf && (r_valid_0 || r_valid_1)) r_ovf <= 1'b1;

            r_valid_0 <= w_beat && adc_enable_0;
            r_valid_1 <= w_beat && adc_enable_1;
            r_data_0  <= adc_data_a;
            r_data_1  <= adc_data_b;
        end
    end

    assign adc_valid_0 = r_valid_0;
    assign adc_valid_1 = r_valid_1;
    assign adc_data_0  = r_data_0;
    assign adc_data_1  = r_data_1;
    assign sts_state   = r_state;
    assign sts_busy    = r_busy;
    assign sts_done    = r_done;
    assign sts_ovf     = r_ovf;
    assign sts_count   = r_count;

endmodule

// File: tb/tb_axi_ad9234_capture_ctrl.sv
// Self-checking bench for axi_ad9234_capture_ctrl: expected per-cycle outputs
// are derived from arm/trigger/holdoff/length arithmetic for each capture.
module tb_axi_ad9234_capture_ctrl;

    logic        adc_clk;
    logic        adc_rst;
    logic        cfg_arm;
    logic        cfg_abort;
    logic [15:0] cfg_length;
    logic [15:0] cfg_holdoff;
    logic [1:0]  cfg_trig_mode;
    logic        trig_in;
    logic        adc_enable_0;
    logic        adc_enable_1;
    logic [63:0] adc_data_a;
    logic [63:0] adc_data_b;
    logic        adc_dovf;
    logic        adc_valid_0;
    logic        adc_valid_1;
    logic [63:0] adc_data_0;
    logic [63:0] adc_data_1;
    logic [2:0]  sts_state;
    logic        sts_busy;
    logic        sts_done;
    logic        sts_ovf;
    logic [15:0] sts_count;

    int checks;
    int failures;
    logic [63:0] prev_a;
    logic [63:0] prev_b;

    axi_ad9234_capture_ctrl dut (
        .adc_clk       (adc_clk),
        .adc_rst       (adc_rst),
        .cfg_arm       (cfg_arm),
        .cfg_abort     (cfg_abort),
        .cfg_length    (cfg_length),
        .cfg_holdoff   (cfg_holdoff),
        .cfg_trig_mode (cfg_trig_mode),
        .trig_in       (trig_in),
        .adc_enable_0  (adc_enable_0),
        .adc_enable_1  (adc_enable_1),
        .adc_data_a    (adc_data_a),
        .adc_data_b    (adc_data_b),
        .adc_dovf      (adc_dovf),
        .adc_valid_0   (adc_valid_0),
        .adc_valid_1   (adc_valid_1),
        .adc_data_0    (adc_data_0),
        .adc_data_1    (adc_data_1),
        .sts_state     (sts_state),
        .sts_busy      (sts_busy),
        .sts_done      (sts_done),
        .sts_ovf       (sts_ovf),
        .sts_count     (sts_count)
    );

    initial adc_clk = 1'b0;
    always #5 adc_clk = ~adc_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge and present fresh sample data.
    task automatic step();
        @(posedge adc_clk);
        #1;
        prev_a     = adc_data_a;
        prev_b     = adc_data_b;
        adc_data_a = {$urandom(), $urandom()};
        adc_data_b = {$urandom(), $urandom()};
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid0"}, 64'(adc_valid_0), 64'd0);
        chk({tag, "_valid1"}, 64'(adc_valid_1), 64'd0);
        chk({tag, "_data0"},  adc_data_0,       64'd0);
        chk({tag, "_data1"},  adc_data_1,       64'd0);
        chk({tag, "_state"},  64'(sts_state),   64'd0);
        chk({tag, "_busy"},   64'(sts_busy),    64'd0);
        chk({tag, "_done"},   64'(sts_done),    64'd0);
        chk({tag, "_ovf"},    64'(sts_ovf),     64'd0);
        chk({tag, "_count"},  64'(sts_count),   64'd0);
    endtask

    // One arm-to-finish capture. Cycle 0 is the arm cycle; t is the trigger
    // cycle, c = t+1+hold the first CAPTURE cycle, strobes trail by one cycle.
    // abort_beat >= 0 aborts on that 0-based CAPTURE cycle (that cycle is no beat).
    task automatic run_capture(input int mode, input int len, input int hold,
                               input bit en0, input bit en1, input int t_in,
                               input int abort_beat, input int ovf_beat,
                               input int rearm_at);
        int t, c, nb, last, dp, exp_state, exp_count;
        bit aborted, exp_v0, exp_v1, exp_done, exp_ovf;
        t       = (mode == 1 || mode == 2) ? t_in : 1;
        c       = t + 1 + hold;
        aborted = (abort_beat >= 0);
        nb      = aborted ? abort_beat : len;
        last    = aborted ? c + abort_beat + 2 : c + len + 1;
        dp      = c + 1 + ovf_beat;

        cfg_arm       = 1'b1;
        cfg_abort     = 1'b0;
        cfg_length    = 16'(len);
        cfg_holdoff   = 16'(hold);
        cfg_trig_mode = 2'(mode);
        adc_enable_0  = en0;
        adc_enable_1  = en1;
        trig_in       = (mode == 1);
        for (int k = 1; k <= last; k++) begin
            step();
            cfg_arm    = (k == rearm_at);
            cfg_length = (k == rearm_at) ? 16'd7 : 16'(len);
            cfg_abort  = aborted && (k == c + abort_beat);
            adc_dovf   = (ovf_beat >= 0) && (k == dp);
            if (mode == 1 || mode == 2) trig_in = (k >= t);
            else                        trig_in = 1'($urandom_range(0, 1));

            if (k <= t)                                       exp_state = 1;
            else if (k < c)                                   exp_state = 2;
            else if (aborted ? (k <= c + abort_beat) : (k < c + len)) exp_state = 3;
            else                                              exp_state = aborted ? 0 : 4;
            exp_v0    = en0 && (k >= c + 1) && (k <= c + nb);
            exp_v1    = en1 && (k >= c + 1) && (k <= c + nb);
            exp_count = (k <= c) ? 0 : ((k - c < nb) ? k - c : nb);
            exp_done  = !aborted && (k >= c + len);
            exp_ovf   = (ovf_beat >= 0) && (en0 || en1) && (dp <= c + nb) && (k > dp);

            chk("state",  64'(sts_state),   64'(exp_state));
            chk("busy",   64'(sts_busy),    64'(exp_state >= 1 && exp_state <= 3));
            chk("valid0", 64'(adc_valid_0), 64'(exp_v0));
            chk("valid1", 64'(adc_valid_1), 64'(exp_v1));
            chk("data0",  adc_data_0,       prev_a);
            chk("data1",  adc_data_1,       prev_b);
            chk("count",  64'(sts_count),   64'(exp_count));
            chk("done",   64'(sts_done),    64'(exp_done));
            chk("ovf",    64'(sts_ovf),     64'(exp_ovf));
        end
        cfg_arm   = 1'b0;
        cfg_abort = 1'b0;
        adc_dovf  = 1'b0;
    endtask

    initial begin
        int len, mode, ab;
        checks        = 0;
        failures      = 0;
        adc_rst       = 1'b1;
        cfg_arm       = 1'b0;
        cfg_abort     = 1'b0;
        cfg_length    = 16'd0;
        cfg_holdoff   = 16'd0;
        cfg_trig_mode = 2'd0;
        trig_in       = 1'b1;
        adc_enable_0  = 1'b1;
        adc_enable_1  = 1'b1;
        adc_data_a    = 64'h1111_2222_3333_4444;
        adc_data_b    = 64'h5555_6666_7777_8888;
        adc_dovf      = 1'b0;
        prev_a        = 64'd0;
        prev_b        = 64'd0;

        // Reset values, with trig_in held high through reset.
        step(); step(); step();
        chk_all_zero("reset");
        adc_rst = 1'b0;
        step();
        chk("post_reset_data0", adc_data_0, prev_a);
        chk("post_reset_state", 64'(sts_state), 64'd0);

        // Immediate capture, L=4, H=0.
        run_capture(0, 4, 0, 1'b1, 1'b1, 1, -1, -1, -1);

        // Edge trigger with holdoff: trig high before arm, rising at cycle 20.
        trig_in = 1'b1;
        step();
        run_capture(1, 3, 5, 1'b1, 1'b1, 20, -1, -1, -1);

        // Abort on the 10th-indexed CAPTURE cycle of a long capture.
        run_capture(0, 100, 0, 1'b1, 1'b1, 1, 10, -1, -1);

        // Arm during CAPTURE is ignored (level mode, holdoff 2).
        run_capture(2, 6, 2, 1'b1, 1'b1, 3, -1, -1, 8);

        // From DONE: arm with abort in the same cycle, then arm with length 0.
        cfg_arm = 1'b1; cfg_abort = 1'b1; cfg_length = 16'd5;
        step();
        cfg_arm = 1'b0; cfg_abort = 1'b0;
        chk("armabort_state", 64'(sts_state), 64'd0);
        chk("armabort_done",  64'(sts_done),  64'd1);
        chk("armabort_count", 64'(sts_count), 64'd6);
        cfg_arm = 1'b1; cfg_length = 16'd0;
        step();
        cfg_arm = 1'b0;
        step();
        chk("len0_state", 64'(sts_state), 64'd0);
        chk("len0_done",  64'(sts_done),  64'd1);
        chk("len0_busy",  64'(sts_busy),  64'd0);

        // Channel 1 disabled, overflow pulsed mid-capture, reserved trigger mode.
        run_capture(3, 8, 0, 1'b1, 1'b0, 1, -1, 3, -1);
        // Next arm clears the sticky overflow.
        run_capture(0, 2, 1, 1'b1, 1'b1, 1, -1, -1, -1);

        // Asynchronous reset mid-capture.
        cfg_arm = 1'b1; cfg_length = 16'd20; cfg_holdoff = 16'd0; cfg_trig_mode = 2'd0;
        adc_enable_0 = 1'b1; adc_enable_1 = 1'b1;
        step();
        cfg_arm = 1'b0;
        step(); step(); step();
        chk("pre_rst_valid0", 64'(adc_valid_0), 64'd1);
        chk("pre_rst_state",  64'(sts_state),   64'd3);
        #1 adc_rst = 1'b1;
        #1 chk_all_zero("async_rst");
        step(); step();
        adc_rst = 1'b0;
        step();
        chk("rst_release_state", 64'(sts_state), 64'd0);
        chk("rst_release_count", 64'(sts_count), 64'd0);
        chk("rst_release_data0", adc_data_0,     prev_a);
        run_capture(0, 5, 2, 1'b1, 1'b1, 1, -1, 1, -1);

        // Randomized captures.
        for (int n = 0; n < 10; n++) begin
            mode = $urandom_range(0, 3);
            len  = $urandom_range(1, 12);
            ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            run_capture(mode, len, $urandom_range(0, 4),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        (mode == 1) ? int'($urandom_range(2, 6)) : int'($urandom_range(1, 6)),
                        ab,
                        ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, len - 1)) : -1,
                        -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
